// File: rtl/mux4_rr_select_pkg.sv
// Shared definitions for the round-robin 4:1 mux select generator.
// Channel and counter widths, FSM encoding and the select-to-grant decode.
package mux4_rr_select_pkg;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] sel);
      onehot4 = 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/mux4_rr_select_rr_pick4.sv
// Combinational round-robin picker: first requesting channel at or after PTR.
// Shared by the idle arbitration and the back-to-back re-arbitration on release.
module rr_pick4
   import mux4_rr_select_pkg::*;
(
   input  logic [N_CH-1:0]  REQ,
   input  logic [SEL_W-1:0] PTR,
   output logic [SEL_W-1:0] o_win,
   output logic             o_any
);

   logic [SEL_W-1:0] w_idx;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      o_win = PTR;
      w_idx = PTR;
      // Walk from farthest to nearest so the closest requester to PTR is written last and wins.
      for (int k = N_CH - 1; k >= 0; k--) begin
         w_idx = PTR + SEL_W'(k);
         if (REQ[w_idx]) begin
            o_win = w_idx;
         end
      end
   end

   assign o_any = |REQ;

endmodule

// File: rtl/mux4_rr_select.sv
// Round-robin select generator for a 4:1 mux: registered select, one-hot grant,
// hold-until-acknowledge handshake and a hold timeout that forces a release.
module mux4_rr_select
   import mux4_rr_select_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic [N_CH-1:0]  REQ,
   input  logic             ADV,
   output logic [SEL_W-1:0] S,
   output logic [N_CH-1:0]  GNT,
   output logic             VALID,
   output logic             TO
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic             TO_EN   = (TIMEOUT != 0);

   state_t           r_state, w_state_nxt;
   logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [SEL_W-1:0] r_s, w_s_nxt;
   logic [N_CH-1:0]  r_gnt, w_gnt_nxt;
   logic             r_to, w_to_nxt;

   logic             w_grant;
   logic             w_adv;
   logic             w_timeout;
   logic             w_release;
   logic [SEL_W-1:0] w_ptr_inc;
   logic [SEL_W-1:0] w_pick_ptr;
   logic [SEL_W-1:0] w_win;
   logic             w_any;

   assign w_grant    = (r_state == ST_GRANT);
   assign w_adv      = w_grant && ADV;
   assign w_timeout  = TO_EN && w_grant && !ADV && (r_cnt == TO_LAST);
   assign w_release  = w_adv || w_timeout;
   assign w_ptr_inc  = r_s + 2'd1;
   // On release the search starts past the channel just served, matching the pointer update.
   assign w_pick_ptr = w_grant ? w_ptr_inc : r_ptr;

   rr_pick4 u_pick (
      .REQ   (REQ),
      .PTR   (w_pick_ptr),
      .o_win (w_win),
      .o_any (w_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_s_nxt     = r_s;
      w_gnt_nxt   = r_gnt;
      w_to_nxt    = w_timeout;

      case (r_state)
         ST_IDLE: begin
            w_gnt_nxt = '0;
            if (w_any) begin
               w_state_nxt = ST_GRANT;
               w_s_nxt     = w_win;
               w_gnt_nxt   = onehot4(w_win);
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_ptr_nxt = w_ptr_inc;
               w_cnt_nxt = '0;
               if (w_any) begin
                  w_s_nxt   = w_win;
                  w_gnt_nxt = onehot4(w_win);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = '0;
               end
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_gnt   <= '0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_s     <= w_s_nxt;
         r_gnt   <= w_gnt_nxt;
         r_to    <= w_to_nxt;
      end
   end

   assign S     = r_s;
   assign GNT   = r_gnt;
   assign VALID = w_grant;
   assign TO    = r_to;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed bench for mux4_rr_select: one instance at the default timeout and
// one at TIMEOUT=4, sharing stimulus; each phase checks the relevant instance.
module tb_mux4_rr_select;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       adv;

   logic [1:0] a_s,   b_s;
   logic [3:0] a_gnt, b_gnt;
   logic       a_valid, b_valid;
   logic       a_to,  b_to;

   int n_checks = 0;
   int n_fail   = 0;

   mux4_rr_select dut_a (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .REQ         (req),
      .ADV         (adv),
      .S           (a_s),
      .GNT         (a_gnt),
      .VALID       (a_valid),
      .TO          (a_to)
   );

   mux4_rr_select #(.TIMEOUT(4)) dut_b (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .REQ         (req),
      .ADV         (adv),
      .S           (b_s),
      .GNT         (b_gnt),
      .VALID       (b_valid),
      .TO          (b_to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [1:0] s,
                        input logic [3:0] g, input logic t);
      check({tag, ".valid"}, 32'(a_valid), 32'(v));
      check({tag, ".s"},     32'(a_s),     32'(s));
      check({tag, ".gnt"},   32'(a_gnt),   32'(g));
      check({tag, ".to"},    32'(a_to),    32'(t));
   endtask

   task automatic chk_b(input string tag, input logic v, input logic [1:0] s,
                        input logic [3:0] g, input logic t);
      check({tag, ".valid"}, 32'(b_valid), 32'(v));
      check({tag, ".s"},     32'(b_s),     32'(s));
      check({tag, ".gnt"},   32'(b_gnt),   32'(g));
      check({tag, ".to"},    32'(b_to),    32'(t));
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      adv   = 1'b0;
      #12;
      chk_a("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
      chk_b("reset_b", 1'b0, 2'd0, 4'b0000, 1'b0);
      tick();
      rst_n = 1'b1;

      // Single request, then acknowledge with nothing pending.
      req = 4'b0100;
      tick();
      chk_a("grant2", 1'b1, 2'd2, 4'b0100, 1'b0);
      adv = 1'b1;
      req = 4'b0000;
      tick();
      chk_a("idle_after_adv", 1'b0, 2'd2, 4'b0000, 1'b0);
      tick();
      chk_a("adv_idle_ignored", 1'b0, 2'd2, 4'b0000, 1'b0);
      adv = 1'b0;
      // PTR is now 3: channel 3 beats channel 0.
      req = 4'b1001;
      tick();
      chk_a("ptr3_pick", 1'b1, 2'd3, 4'b1000, 1'b0);
      adv = 1'b1;
      req = 4'b0000;
      tick();
      chk_a("idle_ptr0", 1'b0, 2'd3, 4'b0000, 1'b0);

      // Back-to-back rotation with every channel requesting.
      adv = 1'b0;
      req = 4'b1111;
      tick();
      chk_a("rr0", 1'b1, 2'd0, 4'b0001, 1'b0);
      adv = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_a($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 4'b0001 << (i % 4), 1'b0);
      end
      req = 4'b0000;
      tick();
      chk_a("rr_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

      // Granted channel drops its request; grant holds until acknowledge. PTR is 1.
      adv = 1'b0;
      req = 4'b0010;
      tick();
      chk_a("hold_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a($sformatf("hold%0d", i), 1'b1, 2'd1, 4'b0010, 1'b0);
      end

      // Asynchronous reset mid-grant, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk_a("async_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
      tick();
      rst_n = 1'b1;
      req   = 4'b1111;
      tick();
      chk_a("ptr_reset", 1'b1, 2'd0, 4'b0001, 1'b0);

      // Timeout behaviour on the TIMEOUT=4 instance.
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      tick();
      rst_n = 1'b1;
      req   = 4'b0011;
      tick();
      chk_b("to_g0", 1'b1, 2'd0, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_b($sformatf("to_hold0_%0d", i), 1'b1, 2'd0, 4'b0001, 1'b0);
      end
      tick();
      chk_b("to_rel1", 1'b1, 2'd1, 4'b0010, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_b($sformatf("to_hold1_%0d", i), 1'b1, 2'd1, 4'b0010, 1'b0);
      end
      tick();
      chk_b("to_rel0", 1'b1, 2'd0, 4'b0001, 1'b1);

      // ADV coinciding with the timeout cycle counts as ADV: no TO pulse.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_b($sformatf("race_hold_%0d", i), 1'b1, 2'd0, 4'b0001, 1'b0);
      end
      adv = 1'b1;
      tick();
      chk_b("race_rel", 1'b1, 2'd1, 4'b0010, 1'b0);
      adv = 1'b0;
      // Counter restarted on the new grant: full four cycles before the next timeout.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_b($sformatf("race_hold1_%0d", i), 1'b1, 2'd1, 4'b0010, 1'b0);
      end
      tick();
      chk_b("race_to", 1'b1, 2'd0, 4'b0001, 1'b1);
      tick();
      chk_b("to_pulse_end", 1'b1, 2'd0, 4'b0001, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
